uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_tx_uart.sv | 55 +++++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter: FSM state
// encoding, frame geometry and the transmitter's idle bit-index marker.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam int         FRAME_BITS  = 10;
    localparam logic [3:0] TX_IDLE_IDX = 4'd15;

    // Serial frame, LSB first on the line: start bit, data LSB first, stop bit.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_tx_uart.sv
// Bit-serial transmitter: shifts out a (BW+1)-bit pre-framed word LSB first,
// each bit held CLOCKS_PER_BAUD cycles. The bit index reads TX_IDLE_IDX when
// no word is in flight and the line is then high.
module tx_uart
    import uart_tx_arbiter_pkg::*;
#(
    parameter int BW              = 9,
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [BW:0]   i_data,
    output logic [3:0]    o_bit_idx,
    output logic          o_txd
);

    localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]            LAST_IDX    = 4'(BW);

    logic [BW:0]           shreg;
    logic [TIMER_BITS-1:0] timer;

    // Bit 0 of the shift register is the bit currently on the line; it is
    // all ones whenever idle so the line rests high.
    assign o_txd = shreg[0];

    // Load on start, then count down each baud period and shift the next bit in.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them see pre-edge values;
        // a blocking = would let later statements read the freshly written value.
        if (i_reset) begin
            shreg     <= '1;
            timer     <= '0;
            o_bit_idx <= TX_IDLE_IDX;
        end else if (i_start) begin
            shreg     <= i_data;
            timer     <= BAUD_RELOAD;
            o_bit_idx <= 4'd0;
        end else if (o_bit_idx != TX_IDLE_IDX) begin
            if (timer != '0) begin
                timer <= timer - TIMER_BITS'(1);
            end else if (o_bit_idx == LAST_IDX) begin
                shreg     <= '1;
                o_bit_idx <= TX_IDLE_IDX;
            end else begin
                timer     <= BAUD_RELOAD;
                shreg     <= {1'b1, shreg[BW:1]};
                o_bit_idx <= o_bit_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that accepts one byte at a time from NREQ requesters,
// frames it and hands it to a single shared UART transmitter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ            = 4,
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_valid,
    input  logic [8*NREQ-1:0] i_data,
    output logic [NREQ-1:0]   o_ready,
    output logic              o_busy,
    output logic [2:0]        o_grant_id,
    output logic              uart_rxd_out
);

    state_t                state;
    state_t                next_state;
    logic [2:0]            last_grant;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            bit_idx;
    logic                  tx_start;

    logic                  found;
    logic [2:0]            pick;
    logic [7:0]            pick_data;
    logic [NREQ-1:0]       pick_onehot;
    logic                  grant;

    // Round-robin search: first valid requester above last_grant, else the
    // first valid one from index 0 up to and including last_grant.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would make synthesis infer a latch.
        found       = 1'b0;
        pick        = '0;
        pick_data   = '0;
        pick_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_valid[k] && (3'(k) > last_grant)) begin
                found          = 1'b1;
                pick           = 3'(k);
                pick_data      = i_data[8*k +: 8];
                pick_onehot[k] = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_valid[k] && (3'(k) <= last_grant)) begin
                found          = 1'b1;
                pick           = 3'(k);
                pick_data      = i_data[8*k +: 8];
                pick_onehot[k] = 1'b1;
            end
        end
    end

    // A grant only commits in IDLE and never in a cycle that is being reset.
    assign grant    = (state == ST_IDLE) && found && !i_reset;
    assign o_ready  = grant ? pick_onehot : '0;
    assign o_busy   = (state != ST_IDLE);
    assign tx_start = (state == ST_START);

    // Next-state logic: IDLE -> START on grant, START -> SEND, SEND -> IDLE
    // once the transmitter reports it has gone idle again.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (grant) next_state = ST_START;
            ST_START: next_state = ST_SEND;
            ST_SEND:  if (bit_idx == TX_IDLE_IDX) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State register plus the grant bookkeeping and latched frame.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            last_grant <= 3'(NREQ - 1);
            frame      <= '1;
            o_grant_id <= '0;
        end else begin
            state <= next_state;
            if (grant) begin
                last_grant <= pick;
                o_grant_id <= pick;
                frame      <= make_frame(pick_data);
            end
        end
    end

    tx_uart #(
        .BW              (9),
        .TIMER_BITS      (TIMER_BITS),
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_tx (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_start   (tx_start),
        .i_data    (frame),
        .o_bit_idx (bit_idx),
        .o_txd     (uart_rxd_out)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a reference model
// that tracks grants, frame timing and the expected serial line.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;
    localparam int PERIOD    = FRAME_CYC + 3;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [NREQ-1:0]   i_valid;
    logic [8*NREQ-1:0] i_data;
    logic [NREQ-1:0]   o_ready;
    logic              o_busy;
    logic [2:0]        o_grant_id;
    logic              uart_rxd_out;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ            (NREQ),
        .TIMER_BITS      (16),
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_busy       (o_busy),
        .o_grant_id   (o_grant_id),
        .uart_rxd_out (uart_rxd_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: a frame granted in cycle g drives the line from
    // g+2 for FRAME_CYC cycles, keeps busy high over g+1 .. g+2+FRAME_CYC, and
    // the next grant may happen no earlier than g+3+FRAME_CYC.
    int          free_at      = 0;
    int          busy_from    = 0;
    int          sched_start  = 0;
    bit          sched_active = 1'b0;
    logic [9:0]  sched_frame  = '1;
    int          last_grant   = NREQ - 1;
    int          exp_gid      = 0;

    logic        line_seen;
    logic        busy_seen;
    int          n_ready = 0;
    int          obs[$];
    int          obs_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        int k;
        for (int i = 1; i <= NREQ; i++) begin
            k = (last + i) % NREQ;
            if (((v >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic exp_line(input int t);
        if (sched_active && t >= sched_start && t < sched_start + FRAME_CYC)
            return sched_frame[(t - sched_start) / CPB];
        return 1'b1;
    endfunction

    // One clock cycle: compare outputs at the falling edge, advance the model.
    task automatic tick();
        logic [NREQ-1:0] exp_ready;
        logic            exp_busy;
        int              k;
        @(negedge clk);
        line_seen = uart_rxd_out;
        busy_seen = o_busy;
        if (!i_reset) begin
            exp_ready = '0;
            k = -1;
            if (cyc >= free_at) begin
                k = rr_pick(i_valid, last_grant);
                if (k >= 0) exp_ready = NREQ'(1) << k;
            end
            exp_busy = (cyc >= busy_from) && (cyc < free_at);
            check("o_ready", 32'(o_ready), 32'(exp_ready));
            check("o_busy", 32'(o_busy), 32'(exp_busy));
            check("line", 32'(uart_rxd_out), 32'(exp_line(cyc)));
            check("grant_id", 32'(o_grant_id), 32'(exp_gid));
            for (int j = 0; j < NREQ; j++) begin
                if (((o_ready >> j) & 1) != 0) begin
                    obs.push_back(j);
                    obs_cyc.push_back(cyc);
                    n_ready++;
                end
            end
            if (k >= 0) begin
                sched_frame  = {1'b1, 8'(i_data >> (8 * k)), 1'b0};
                sched_start  = cyc + 2;
                sched_active = 1'b1;
                busy_from    = cyc + 1;
                free_at      = cyc + 3 + FRAME_CYC;
                last_grant   = k;
                exp_gid      = k;
            end
        end else begin
            sched_active = 1'b0;
            free_at      = cyc + 1;
            busy_from    = cyc + 1;
            last_grant   = NREQ - 1;
            exp_gid      = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = '0;
        repeat (3) tick();
        i_reset = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_a5;
        i_reset = 1'b1;
        i_valid = '0;
        i_data  = '0;

        // Single byte 0xA5 from requester 0.
        do_reset();
        tick();
        check("reset_busy", 32'(busy_seen), 32'd0);
        check("reset_line", 32'(line_seen), 32'd1);
        exp_a5  = 10'b1101001010;
        i_data  = 32'($urandom);
        i_data[7:0] = 8'hA5;
        i_valid = 4'b0001;
        n_ready = 0;
        tick();
        i_valid = '0;
        tick();
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                if (c == 1) check("a5_bit", 32'(line_seen), 32'(exp_a5[b]));
            end
        end
        tick();
        check("a5_busy_stop", 32'(busy_seen), 32'd1);
        tick();
        check("a5_busy_fall", 32'(busy_seen), 32'd0);
        check("a5_ready_count", 32'(n_ready), 32'd1);

        // Fairness with every requester permanently valid.
        do_reset();
        obs.delete();
        n_ready = 0;
        i_valid = '1;
        repeat (5 * PERIOD) tick();
        i_valid = '0;
        repeat (PERIOD) tick();
        check("fair_count", 32'(obs.size()), 32'd5);
        if (obs.size() == 5) begin
            check("fair_g0", 32'(obs[0]), 32'd0);
            check("fair_g1", 32'(obs[1]), 32'd1);
            check("fair_g2", 32'(obs[2]), 32'd2);
            check("fair_g3", 32'(obs[3]), 32'd3);
            check("fair_g4", 32'(obs[4]), 32'd0);
        end

        // Wrap-around from last_grant = 2 with requesters 0 and 1 valid.
        do_reset();
        obs.delete();
        i_valid = 4'b0100;
        tick();
        i_valid = '0;
        repeat (PERIOD) tick();
        i_valid = 4'b0011;
        repeat (2 * PERIOD) tick();
        i_valid = '0;
        repeat (PERIOD) tick();
        check("wrap_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            check("wrap_g0", 32'(obs[0]), 32'd2);
            check("wrap_g1", 32'(obs[1]), 32'd0);
            check("wrap_g2", 32'(obs[2]), 32'd1);
        end

        // Reset in the middle of a 0x00 frame.
        do_reset();
        i_data[7:0] = 8'h00;
        i_valid = 4'b0001;
        tick();
        i_valid = '0;
        repeat (9) tick();
        check("abort_pre_line", 32'(line_seen), 32'd0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_ready = 0;
        tick();
        check("abort_line", 32'(line_seen), 32'd1);
        check("abort_busy", 32'(busy_seen), 32'd0);
        repeat (PERIOD) tick();
        check("abort_no_ready", 32'(n_ready), 32'd0);

        // Late valid: requester 2 rises during requester 1's frame, and
        // requester 1's data changes after its grant.
        obs.delete();
        obs_cyc.delete();
        i_data[15:8] = 8'h3C;
        i_valid = 4'b0010;
        tick();
        i_valid = '0;
        repeat (6) tick();
        i_valid = 4'b0100;
        i_data  = 32'($urandom);
        repeat (PERIOD) tick();
        i_valid = '0;
        repeat (PERIOD) tick();
        check("late_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            check("late_g0", 32'(obs[0]), 32'd1);
            check("late_g1", 32'(obs[1]), 32'd2);
            check("late_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'(PERIOD));
        end

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(7) == 0) i_valid = i_valid ^ (NREQ'(1) << r);
                if ($urandom_range(3) == 0) i_data[8*r +: 8] = 8'($urandom);
            end
            i_reset = ($urandom_range(399) == 0);
            tick();
        end
        i_reset = 1'b0;
        i_valid = '0;
        repeat (PERIOD) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
